// File: rtl/key_display_pkg.sv
// key_display_pkg: register offsets, SSDC bit indices and seven-segment decode
// shared by the key/display controller and its debouncer.
package key_display_pkg;
  localparam logic [3:0] LEDC     = 4'h0;
  localparam logic [3:0] SSDC     = 4'h1;
  localparam logic [3:0] KEYS     = 4'h2;
  localparam logic [3:0] KDIE     = 4'h3;
  localparam logic [3:0] DIG_BASE = 4'h8;
  localparam int SSDC_EN  = 0;
  localparam int SSDC_HEX = 1;
  // Active-low {g,f,e,d,c,b,a}
  typedef enum logic [6:0] {
    SEG_0 = 7'h40, SEG_1 = 7'h79, SEG_2 = 7'h24, SEG_3 = 7'h30,
    SEG_4 = 7'h19, SEG_5 = 7'h12, SEG_6 = 7'h02, SEG_7 = 7'h78,
    SEG_8 = 7'h00, SEG_9 = 7'h10, SEG_A = 7'h08, SEG_B = 7'h03,
    SEG_C = 7'h46, SEG_D = 7'h21, SEG_E = 7'h06, SEG_F = 7'h0E,
    SEG_BLANK = 7'h7F
  } seg_code_e;
  function automatic seg_code_e seg_decode(input logic [3:0] v, input logic hex);
    case (v)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return hex ? SEG_A : SEG_BLANK;
      4'hB: return hex ? SEG_B : SEG_BLANK;
      4'hC: return hex ? SEG_C : SEG_BLANK;
      4'hD: return hex ? SEG_D : SEG_BLANK;
      4'hE: return hex ? SEG_E : SEG_BLANK;
      default: return hex ? SEG_F : SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/key_display_ctrl_if.sv
// key_display_ctrl_if: register-bus handshake between the I/O decoder and the key/display block.
interface key_display_ctrl_if;
  logic        BlockSelect;
  logic [3:0]  RegAddress;
  logic        WrEn;
  logic [31:0] WrData;
  logic        RdEn;
  logic [31:0] RdData;
  logic        KeyPressInt;
  modport master (output BlockSelect, RegAddress, WrEn, WrData, RdEn, input RdData, KeyPressInt);
  modport slave  (input BlockSelect, RegAddress, WrEn, WrData, RdEn, output RdData, KeyPressInt);
endinterface

// File: rtl/key_debouncer.sv
// key_debouncer: 2-flop synchroniser plus stability counter for one active-low key,
// emitting 1-cycle press (1->0) and release (0->1) pulses on accepted transitions.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 150000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o,
  output logic rel_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0]    sync_q;
  logic          stable_q, press_q, rel_q, accept;
  logic [DW-1:0] cnt_q;
  assign accept  = (sync_q[1] != stable_q) && (cnt_q == DW'(DEBOUNCE_CYCLES - 1));
  assign press_o = press_q;
  assign rel_o   = rel_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_i};
      cnt_q    <= (sync_q[1] == stable_q || accept) ? '0 : cnt_q + DW'(1);
      stable_q <= accept ? sync_q[1] : stable_q;
      press_q  <= accept & ~sync_q[1];
      rel_q    <= accept & sync_q[1];
    end
endmodule

// File: rtl/key_display_ctrl.sv
// key_display_ctrl: LED register, multiplexed seven-segment scan and debounced key events.
// Optional: define KEY_RELEASE_EVT_EN to latch release events in KEYS/KDIE[31:16].
module key_display_ctrl
  import key_display_pkg::*;
#(
  parameter int NUM_DIGITS      = 6,
  parameter int NUM_KEYS        = 4,
  parameter int NUM_LEDS        = 4,
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 150000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  key_display_ctrl_if.slave     bus,
  output logic [NUM_LEDS-1:0]   LED,
  output logic [7:0]            Segment,
  output logic [NUM_DIGITS-1:0] Digital,
  input  logic [NUM_KEYS-1:0]   Keys
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [31:0] KEY_MASK = 32'((64'd1 << NUM_KEYS) - 64'd1);
`ifdef KEY_RELEASE_EVT_EN
  localparam logic [31:0] EV_MASK = KEY_MASK | (KEY_MASK << 16);
`else
  localparam logic [31:0] EV_MASK = KEY_MASK;
`endif
  logic [NUM_LEDS-1:0]   led_q;
  logic [1:0]            ssdc_q;
  logic [31:0]           keys_q, keys_d, kdie_q, kdie_d, ev_set, rd_mux, rd_q;
  logic [4:0]            dig_q [8];
  logic [CW-1:0]         cnt_q;
  logic [2:0]            idx_q, idx_d;
  logic [NUM_DIGITS-1:0] digital_q;
  logic                  int_q, wr, rd, tc, dig_hit;
  logic [NUM_KEYS-1:0]   press, rel;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(Clock), .rst_n(Reset), .key_i(Keys[k]), .press_o(press[k]), .rel_o(rel[k])
    );
  end
  assign wr      = bus.BlockSelect & bus.WrEn;
  assign rd      = bus.BlockSelect & bus.RdEn;
  assign dig_hit = bus.RegAddress[3] && ({1'b0, bus.RegAddress[2:0]} < 4'(NUM_DIGITS));
  assign tc      = ssdc_q[SSDC_EN] && (cnt_q == CW'(SCAN_DIV - 1));
  assign idx_d   = !tc ? idx_q : (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
  assign ev_set  = (32'(press) | (32'(rel) << 16)) & EV_MASK;
  // A press arriving in the clearing cycle survives the clear.
  assign keys_d  = ((rd && bus.RegAddress == KEYS) ? 32'd0 : keys_q) | ev_set;
  assign kdie_d  = (wr && bus.RegAddress == KDIE) ? bus.WrData & EV_MASK : kdie_q;
  always_comb
    rd_mux = bus.RegAddress == LEDC ? 32'(led_q) :
             bus.RegAddress == SSDC ? 32'(ssdc_q) :
             bus.RegAddress == KEYS ? keys_q :
             bus.RegAddress == KDIE ? kdie_q :
             dig_hit                ? 32'(dig_q[bus.RegAddress[2:0]]) : 32'd0;
  assign Segment         = ssdc_q[SSDC_EN]
                           ? {~dig_q[idx_q][4], seg_decode(dig_q[idx_q][3:0], ssdc_q[SSDC_HEX])}
                           : 8'hFF;
  assign LED             = led_q;
  assign Digital         = digital_q;
  assign bus.RdData      = rd_q;
  assign bus.KeyPressInt = int_q;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      led_q     <= '0;
      ssdc_q    <= '0;
      keys_q    <= '0;
      kdie_q    <= '0;
      rd_q      <= '0;
      int_q     <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      digital_q <= NUM_DIGITS'(1);
      for (int i = 0; i < 8; i++) dig_q[i] <= '0;
    end else begin
      if (wr && bus.RegAddress == LEDC) led_q <= bus.WrData[NUM_LEDS-1:0];
      if (wr && bus.RegAddress == SSDC) ssdc_q <= bus.WrData[1:0];
      if (wr && dig_hit) dig_q[bus.RegAddress[2:0]] <= bus.WrData[4:0];
      keys_q <= keys_d;
      kdie_q <= kdie_d;
      int_q  <= |(keys_d & kdie_d);
      if (rd) rd_q <= rd_mux;
      if (ssdc_q[SSDC_EN]) cnt_q <= tc ? '0 : cnt_q + CW'(1);
      idx_q <= idx_d;
      if (tc) digital_q <= NUM_DIGITS'(1) << idx_d;
    end
endmodule

// File: tb/tb_key_display_ctrl.sv
// tb_key_display_ctrl: directed register, scan, decode, debounce and reset checks
// with hand-computed expectations (SCAN_DIV=4, DEBOUNCE_CYCLES=8).
module tb_key_display_ctrl;
  import key_display_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] led;
  logic [7:0] seg;
  logic [5:0] digital;
  logic [3:0] keys;
  int checks = 0;
  int errors = 0;
  logic [31:0] d;
  // Segment patterns for digit values 1..6 with dp off
  localparam logic [7:0] SEGS [6] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
  key_display_ctrl_if bus ();
  key_display_ctrl #(
    .NUM_DIGITS(6), .NUM_KEYS(4), .NUM_LEDS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8)
  ) dut (
    .Clock(clk), .Reset(rst_n), .bus(bus.slave),
    .LED(led), .Segment(seg), .Digital(digital), .Keys(keys)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    bus.BlockSelect = 1'b1; bus.WrEn = 1'b1; bus.RegAddress = a; bus.WrData = v;
    @(negedge clk);
    bus.BlockSelect = 1'b0; bus.WrEn = 1'b0;
  endtask
  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.BlockSelect = 1'b1; bus.RdEn = 1'b1; bus.RegAddress = a;
    @(negedge clk);
    bus.BlockSelect = 1'b0; bus.RdEn = 1'b0;
    v = bus.RdData;
  endtask
  task automatic wait_dig(input logic [5:0] t);
    int n = 0;
    while (digital !== t && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_digit", 32'(digital), 32'(t));
  endtask
  initial begin
    rst_n = 1'b0; keys = 4'hF;
    bus.BlockSelect = 1'b0; bus.WrEn = 1'b0; bus.RdEn = 1'b0;
    bus.RegAddress = 4'h0; bus.WrData = 32'h0;
    #12;
    check("rst_led", 32'(led), 32'h0);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_digital", 32'(digital), 32'h1);
    check("rst_rddata", bus.RdData, 32'h0);
    check("rst_int", 32'(bus.KeyPressInt), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    wr(LEDC, 32'hFFFF_FFFA);
    check("led_out", 32'(led), 32'hA);
    rd(LEDC, d); check("ledc_rd", d, 32'hA);
    wr(4'h4, 32'h1234); rd(4'h4, d); check("unmapped_rd", d, 32'h0);
    wr(4'hE, 32'h1F); rd(4'hE, d); check("dig_oor_rd", d, 32'h0);
    wr(SSDC, 32'h7); rd(SSDC, d); check("ssdc_rd", d, 32'h3);
    wr(SSDC, 32'h0);
    for (int i = 0; i < 6; i++) wr(DIG_BASE + 4'(i), 32'(i + 1));
    rd(DIG_BASE + 4'd5, d); check("dig5_rd", d, 32'h6);
    check("seg_disabled", 32'(seg), 32'hFF);
    wr(SSDC, 32'h1);
    wait_dig(6'h2);
    for (int k = 0; k < 7; k++)
      for (int s = 0; s < 4; s++) begin
        check("scan_digital", 32'(digital), 32'h1 << ((k + 1) % 6));
        check("scan_seg", 32'(seg), 32'(SEGS[(k + 1) % 6]));
        @(negedge clk);
      end
    // Counter is 0 here on digit 2; the disable lands with the count at 2
    check("freeze_pre", 32'(digital), 32'h4);
    wr(SSDC, 32'h0);
    check("freeze_seg", 32'(seg), 32'hFF);
    repeat (10) @(negedge clk);
    check("freeze_digital", 32'(digital), 32'h4);
    wr(SSDC, 32'h1);
    check("resume_0", 32'(digital), 32'h4);
    @(negedge clk); check("resume_1", 32'(digital), 32'h4);
    @(negedge clk); check("resume_2", 32'(digital), 32'h8);
    wr(DIG_BASE + 4'd2, 32'h0B);
    wait_dig(6'h4); check("blank_b", 32'(seg), 32'hFF);
    wr(SSDC, 32'h3);
    wait_dig(6'h4); check("hex_b", 32'(seg), 32'h83);
    wr(DIG_BASE + 4'd3, 32'h13);
    wait_dig(6'h8); check("dp_seg", 32'(seg), 32'h30);
    rd(DIG_BASE + 4'd3, d); check("dig3_rd", d, 32'h13);
    wr(SSDC, 32'h0);
    wr(KDIE, 32'h0);
    keys[1] = 1'b0; repeat (5) @(negedge clk); keys[1] = 1'b1;
    repeat (20) @(negedge clk);
    rd(KEYS, d); check("bounce_keys", d, 32'h0);
    check("bounce_int", 32'(bus.KeyPressInt), 32'h0);
    keys[1] = 1'b0; repeat (20) @(negedge clk);
    check("masked_int", 32'(bus.KeyPressInt), 32'h0);
    rd(KEYS, d); check("hold_keys", d, 32'h2);
    rd(KEYS, d); check("hold_once", d, 32'h0);
    keys[1] = 1'b1; repeat (20) @(negedge clk);
    rd(KEYS, d); check("release_ignored", d, 32'h0);
    wr(KDIE, 32'hFFFF_FFFF); rd(KDIE, d); check("kdie_rd", d, 32'hF);
    wr(KDIE, 32'h3);
    keys[1] = 1'b0; repeat (20) @(negedge clk);
    check("unmasked_int", 32'(bus.KeyPressInt), 32'h1);
    rd(KEYS, d); check("int_keys", d, 32'h2);
    check("int_clear", 32'(bus.KeyPressInt), 32'h0);
    wr(KDIE, 32'h7);
    keys[2] = 1'b0; repeat (20) @(negedge clk);
    check("coll_pre_int", 32'(bus.KeyPressInt), 32'h1);
    // Key0 press pulse reaches the flag register on the 11th edge after the drive
    keys[0] = 1'b0;
    repeat (9) @(negedge clk);
    rd(KEYS, d); check("coll_old", d, 32'h4);
    check("coll_int", 32'(bus.KeyPressInt), 32'h1);
    rd(KEYS, d); check("coll_kept", d, 32'h1);
    check("coll_int_clr", 32'(bus.KeyPressInt), 32'h0);
    keys = 4'hF; repeat (20) @(negedge clk);
    wr(KDIE, 32'h1); wr(LEDC, 32'h5); wr(SSDC, 32'h1);
    rd(LEDC, d); check("pre_rst_rd", d, 32'h5);
    keys[0] = 1'b0; repeat (20) @(negedge clk);
    check("pre_rst_int", 32'(bus.KeyPressInt), 32'h1);
    keys[2] = 1'b0; repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'h0);
    check("arst_seg", 32'(seg), 32'hFF);
    check("arst_digital", 32'(digital), 32'h1);
    check("arst_rddata", bus.RdData, 32'h0);
    check("arst_int", 32'(bus.KeyPressInt), 32'h0);
    keys = 4'hF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_int", 32'(bus.KeyPressInt), 32'h0);
    check("post_rst_digital", 32'(digital), 32'h1);
    rd(KEYS, d); check("post_rst_keys", d, 32'h0);
    rd(SSDC, d); check("post_rst_ssdc", d, 32'h0);
    rd(KDIE, d); check("post_rst_kdie", d, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
